// File: rtl/alu_pkg.sv
// Shared constants for the sequential ALU: opcodes, status flag bit positions
// and the control FSM state encoding.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_SHR = 4'd3;
  localparam logic [3:0] OP_SHL = 4'd4;
  localparam logic [3:0] OP_DIV = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_AND = 4'd7;
  localparam logic [3:0] OP_OR  = 4'd8;
  localparam logic [3:0] OP_XOR = 4'd9;
  localparam logic [3:0] OP_ONE = 4'd10;

  // flags = {err, dz, ovf, carry, zero}
  localparam int FLG_ZERO  = 0;
  localparam int FLG_CARRY = 1;
  localparam int FLG_OVF   = 2;
  localparam int FLG_DZ    = 3;
  localparam int FLG_ERR   = 4;
  localparam int FLG_W     = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_div_iter.sv
// Restoring divider, one quotient bit per cycle. o_done is high in the cycle of the
// final iteration; o_quot/o_rem then carry the finished values for the parent to register.
module alu_div_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quot,
  output logic [WIDTH-1:0] o_rem
);

  localparam int CW = $clog2(WIDTH);

  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_divisor;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_quot_nx;

  // Shift the next dividend bit into the partial remainder; keep the subtraction
  // only when it does not go negative (top bit of the WIDTH+1 difference clear).
  always_comb begin
    w_shift   = {r_rem, r_quot[WIDTH-1]};
    w_diff    = w_shift - {1'b0, r_divisor};
    w_ge      = ~w_diff[WIDTH];
    w_rem_nx  = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    w_quot_nx = {r_quot[WIDTH-2:0], w_ge};
  end

  assign o_done = r_busy & (r_cnt == CW'(WIDTH - 1));
  assign o_quot = w_quot_nx;
  assign o_rem  = w_rem_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy    <= 1'b0;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_divisor <= '0;
    end else if (i_start) begin
      r_busy    <= 1'b1;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quot    <= i_dividend;
      r_divisor <= i_divisor;
    end else if (r_busy) begin
      r_rem  <= w_rem_nx;
      r_quot <= w_quot_nx;
      r_cnt  <= r_cnt + CW'(1);
      if (o_done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: valid/ready operand intake, single-cycle datapath for most ops,
// iterative divide, registered result and flags held until the consumer takes them.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int RES_WIDTH = 2 * WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [3:0]           opsel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RES_WIDTH-1:0] result,
  output logic [FLG_W-1:0]     flags,
  output logic [1:0]           o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
  // in_ready never depends on in_valid; out_valid/result/flags stay put until taken.

  state_t r_state, w_state_nx;
  logic [RES_WIDTH-1:0] r_result;
  logic [FLG_W-1:0]     r_flags;

  logic w_accept, w_div_start, w_div_done;
  logic [WIDTH-1:0] w_div_quot, w_div_rem;

  logic [WIDTH:0]       w_sum, w_dif;
  logic [2*WIDTH-1:0]   w_prod;
  logic [RES_WIDTH-1:0] w_res, w_div_res;
  logic [FLG_W-1:0]     w_flags, w_div_flags;

  always_comb begin
    w_sum  = {1'b0, a} + {1'b0, b};
    w_dif  = {1'b0, a} - {1'b0, b};
    w_prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  end

  always_comb begin
    w_res   = '0;
    w_flags = '0;
    case (opsel)
      OP_ADD: begin
        w_res[WIDTH:0]   = w_sum;
        w_flags[FLG_CARRY] = w_sum[WIDTH];
        w_flags[FLG_OVF]   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res[WIDTH-1:0] = w_dif[WIDTH-1:0];
        w_flags[FLG_CARRY] = w_dif[WIDTH];
        w_flags[FLG_OVF]   = (a[WIDTH-1] != b[WIDTH-1]) && (w_dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_MUL: w_res[2*WIDTH-1:0] = w_prod;
      OP_SHR: if (b < WIDTH'(WIDTH)) w_res[WIDTH-1:0] = a >> b;
      OP_SHL: if (b < WIDTH'(WIDTH)) w_res[WIDTH-1:0] = a << b;
      OP_DIV: begin
        // Only the divide-by-zero case resolves here; others go to the divider.
        w_res[2*WIDTH-1:0] = {a, {WIDTH{1'b1}}};
        w_flags[FLG_DZ]    = 1'b1;
      end
      OP_NOT: w_res[WIDTH-1:0] = ~a;
      OP_AND: w_res[WIDTH-1:0] = a & b;
      OP_OR:  w_res[WIDTH-1:0] = a | b;
      OP_XOR: w_res[WIDTH-1:0] = a ^ b;
      OP_ONE: w_res[0] = 1'b1;
      default: w_flags[FLG_ERR] = 1'b1;
    endcase
    w_flags[FLG_ZERO] = (w_res == '0);
  end

  always_comb begin
    w_div_res                = '0;
    w_div_res[2*WIDTH-1:0]   = {w_div_rem, w_div_quot};
    w_div_flags              = '0;
    w_div_flags[FLG_ZERO]    = (w_div_res == '0);
  end

  always_comb begin
    in_ready    = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    w_accept    = in_valid && in_ready;
    w_div_start = w_accept && (opsel == OP_DIV) && (b != '0);
    w_state_nx  = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nx = w_div_start ? ST_DIV : ST_DONE;
      ST_DIV:  if (w_div_done) w_state_nx = ST_DONE;
      ST_DONE: begin
        if (w_accept)       w_state_nx = w_div_start ? ST_DIV : ST_DONE;
        else if (out_ready) w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_accept && !w_div_start) begin
        r_result <= w_res;
        r_flags  <= w_flags;
      end else if (w_div_done) begin
        r_result <= w_div_res;
        r_flags  <= w_div_flags;
      end
    end
  end

  alu_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_div_start),
    .i_dividend (a),
    .i_divisor  (b),
    .o_done     (w_div_done),
    .o_quot     (w_div_quot),
    .o_rem      (w_div_rem)
  );

  assign out_valid   = (r_state == ST_DONE);
  assign result      = r_result;
  assign flags       = r_flags;
  assign o_dbg_state = r_state;

endmodule
